mips_muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath. It sits beside the single-cycle ALU and executes the R-type funct codes the ALU control leaves undecoded: mult, multu, div, divu, mfhi, mflo, mthi and mtlo. Multiply and divide operations take several cycles and use a start/busy/done handshake. The core stalls its PC while `busy` is high.

---
 rtl/mips_muldiv_unit.sv | 145 ++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO for the MIPS datapath.
// One magnitude bit per RUN cycle, sign fix-up and HI/LO write in FIX.
module mips_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;

  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MTHI = 6'b010001;
  localparam logic [5:0] F_MTLO = 6'b010011;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t state, state_next;

  logic [CW-1:0]    cnt;
  logic             op_div, neg_q, neg_r, b_zero;
  logic [WIDTH-1:0] operand, acc_hi, acc_lo;

  logic             is_muldiv, op_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   add_sum, shifted;
  logic [WIDTH-1:0] diff, step_hi, step_lo, fix_hi, fix_lo;
  logic [PW-1:0]    product;

  // mult/multu/div/divu share funct[5:2]; bit1 selects divide, bit0 unsigned
  assign is_muldiv = (funct[5:2] == 4'b0110);
  assign op_signed = ~funct[0];
  assign a_neg     = op_signed & rs_data[WIDTH-1];
  assign b_neg     = op_signed & rt_data[WIDTH-1];
  assign a_mag     = a_neg ? (~rs_data + WIDTH'(1)) : rs_data;
  assign b_mag     = b_neg ? (~rt_data + WIDTH'(1)) : rt_data;

  assign result = (funct == F_MFHI) ? hi : lo;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && is_muldiv) state_next = RUN;
      RUN:     if (cnt == CW'(WIDTH - 1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One iteration: shift-add multiply or restoring shift-subtract divide
  always_comb begin
    add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    diff    = shifted[WIDTH-1:0] - operand;
    step_hi = add_sum[WIDTH:1];
    step_lo = {add_sum[0], acc_lo[WIDTH-1:1]};
    if (op_div) begin
      if (shifted >= {1'b0, operand}) begin
        step_hi = diff;
        step_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = shifted[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  // With a zero divisor every trial succeeds, so the remainder path ends
  // holding the dividend magnitude and its sign fix-up restores rs_data.
  always_comb begin
    product = neg_q ? (~{acc_hi, acc_lo} + PW'(1)) : {acc_hi, acc_lo};
    fix_hi  = product[PW-1:WIDTH];
    fix_lo  = product[WIDTH-1:0];
    if (op_div) begin
      fix_hi = neg_r ? (~acc_hi + WIDTH'(1)) : acc_hi;
      fix_lo = b_zero ? '1 : (neg_q ? (~acc_lo + WIDTH'(1)) : acc_lo);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      cnt         <= '0;
      op_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      b_zero      <= 1'b0;
      operand     <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
    end else begin
      state       <= state_next;
      busy        <= (state_next != IDLE);
      done        <= (state == FIX);
      div_by_zero <= (state == FIX) && op_div && b_zero;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_muldiv) begin
              cnt     <= '0;
              op_div  <= funct[1];
              neg_q   <= a_neg ^ b_neg;
              neg_r   <= a_neg;
              b_zero  <= (rt_data == '0);
              operand <= funct[1] ? b_mag : a_mag;
              acc_hi  <= '0;
              acc_lo  <= funct[1] ? a_mag : b_mag;
            end else if (funct == F_MTHI) begin
              hi <= rs_data;
            end else if (funct == F_MTLO) begin
              lo <= rs_data;
            end
          end
        end
        RUN: begin
          cnt    <= cnt + CW'(1);
          acc_hi <= step_hi;
          acc_lo <= step_lo;
        end
        FIX: begin
          hi <= fix_hi;
          lo <= fix_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: vector table, scoreboard queue,
// and hand-written handshake/reset/register-move sequences.
module tb_mips_muldiv_unit;

  localparam int unsigned W = 32;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;

  logic         clk;
  logic         reset;
  logic         start;
  logic [5:0]   funct;
  logic [W-1:0] rs_data, rt_data;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo, result;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } res_t;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    res_t        want;
  } vec_t;

  res_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  mips_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .funct(funct),
    .rs_data(rs_data), .rt_data(rt_data), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  // Reference results from native operators, independent of the iterative datapath
  function automatic res_t model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    res_t        r;
    longint      p;
    logic [63:0] u;
    int          q, m;
    r = '{32'h0, 32'h0, 1'b0};
    case (f)
      F_MULT: begin
        p = longint'(signed'(a)) * longint'(signed'(b));
        r.hi = p[63:32];
        r.lo = p[31:0];
      end
      F_MULTU: begin
        u = {32'h0, a} * {32'h0, b};
        r.hi = u[63:32];
        r.lo = u[31:0];
      end
      F_DIV, F_DIVU: begin
        if (b == 32'h0) begin
          r = '{a, 32'hFFFFFFFF, 1'b1};
        end else if (f == F_DIVU) begin
          r.lo = a / b;
          r.hi = a % b;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          r.lo = a;
          r.hi = 32'h0;
        end else begin
          q = signed'(a) / signed'(b);
          m = signed'(a) % signed'(b);
          r.lo = q;
          r.hi = m;
        end
      end
      default: ;
    endcase
    return r;
  endfunction

  // Drive an issue at a negedge; operands are scrambled afterwards to prove latching
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    start   = 1'b1;
    funct   = f;
    rs_data = a;
    rt_data = b;
    @(negedge clk);
    start   = 1'b0;
    funct   = F_MULT;
    rs_data = $urandom;
    rt_data = $urandom;
  endtask

  task automatic finish_op(input string name, input int busy_want);
    int   n;
    bit   seen;
    res_t w;
    n    = 0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) n++;
      @(negedge clk);
    end
    check({name, " done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({name, " busy_cycles"}, 32'(n), 32'(busy_want));
      check({name, " busy_at_done"}, 32'(busy), 32'd0);
      if (sb.size() == 0) begin
        check({name, " scoreboard_empty"}, 32'd1, 32'd0);
      end else begin
        w = sb.pop_front();
        check({name, " hi"}, hi, w.hi);
        check({name, " lo"}, lo, w.lo);
        check({name, " div_by_zero"}, 32'(div_by_zero), 32'(w.dbz));
      end
    end
  endtask

  vec_t tbl[16];

  initial begin
    logic [5:0]  rf;
    logic [31:0] ra, rb;
    int          cnt_evt;

    tbl[0] = '{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, '{32'hFFFFFFFE, 32'h00000001, 1'b0}};
    tbl[1] = '{F_MULT,  32'hFFFFFFF9, 32'h00000006, '{32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0}};
    tbl[2] = '{F_DIV,   32'hFFFFFFF9, 32'h00000002, '{32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0}};
    tbl[3] = '{F_DIVU,  32'd100,      32'd7,        '{32'd2,        32'd14,        1'b0}};
    tbl[4] = '{F_DIV,   32'h12345678, 32'h00000000, '{32'h12345678, 32'hFFFFFFFF, 1'b1}};
    tbl[5] = '{F_DIV,   32'h80000000, 32'hFFFFFFFF, '{32'h00000000, 32'h80000000, 1'b0}};
    tbl[6] = '{F_DIV,   32'h80000001, 32'h00000000, '{32'h80000001, 32'hFFFFFFFF, 1'b1}};
    tbl[7] = '{F_MULT,  32'h80000000, 32'h80000000, '{32'h40000000, 32'h00000000, 1'b0}};
    tbl[8] = '{F_DIV,   32'h00000007, 32'hFFFFFFFE, '{32'h00000001, 32'hFFFFFFFD, 1'b0}};
    tbl[9] = '{F_DIVU,  32'hFFFFFFFF, 32'h00000000, '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1}};
    for (int i = 10; i < 16; i++) begin
      rf = F_MULT + 6'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (rf[1] && i[0]) rb = rb >> 20;
      tbl[i] = '{rf, ra, rb, model(rf, ra, rb)};
    end

    reset   = 1'b1;
    start   = 1'b0;
    funct   = 6'h0;
    rs_data = '0;
    rt_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset div_by_zero", 32'(div_by_zero), 32'd0);
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);

    for (int i = 0; i < 16; i++) begin
      sb.push_back(tbl[i].want);
      issue(tbl[i].f, tbl[i].a, tbl[i].b);
      finish_op($sformatf("vec%0d", i), 33);
      @(negedge clk);
      check($sformatf("vec%0d done_pulse", i), 32'(done), 32'd0);
      check($sformatf("vec%0d dbz_pulse", i), 32'(div_by_zero), 32'd0);
    end

    // start during RUN (mthi and a new mult) must be ignored
    sb.push_back(model(F_MULTU, 32'd1000, 32'd7));
    issue(F_MULTU, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    start = 1'b1; funct = F_MTHI; rs_data = 32'hDEADBEEF;
    @(negedge clk);
    funct = F_MULT; rs_data = 32'd3; rt_data = 32'd5;
    @(negedge clk);
    start = 1'b0;
    finish_op("midrun", 22);
    @(negedge clk);

    // reset during RUN cycle 10 discards the operation
    issue(F_MULT, 32'h00012345, 32'h00054321);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("runreset busy", 32'(busy), 32'd0);
    check("runreset hi", hi, 32'h0);
    check("runreset lo", lo, 32'h0);
    cnt_evt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) cnt_evt++;
      @(negedge clk);
    end
    check("runreset no_done", 32'(cnt_evt), 32'd0);

    // back-to-back: next mult issued in the done cycle
    sb.push_back(model(F_MULT, 32'hFFFF0001, 32'd12345));
    issue(F_MULT, 32'hFFFF0001, 32'd12345);
    finish_op("b2b_first", 33);
    sb.push_back(model(F_MULT, 32'hFFFFFFFD, 32'hFFFFFFFB));
    issue(F_MULT, 32'hFFFFFFFD, 32'hFFFFFFFB);
    finish_op("b2b_second", 33);
    @(negedge clk);

    // reset beats start on the same edge
    reset = 1'b1; start = 1'b1; funct = F_MTHI; rs_data = 32'h00001234;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("rst_prio hi", hi, 32'h0);
    check("rst_prio busy", 32'(busy), 32'd0);

    // register moves
    start = 1'b1; funct = F_MTHI; rs_data = 32'hA5A5A5A5;
    @(negedge clk);
    check("mthi hi", hi, 32'hA5A5A5A5);
    check("mthi busy", 32'(busy), 32'd0);
    funct = F_MTLO; rs_data = 32'h5A5A5A5A;
    @(negedge clk);
    start = 1'b0;
    check("mtlo lo", lo, 32'h5A5A5A5A);
    check("mtlo hi_kept", hi, 32'hA5A5A5A5);
    check("mtlo busy", 32'(busy), 32'd0);
    check("mtlo done", 32'(done), 32'd0);
    funct = F_MFHI;
    #1 check("result mfhi", result, 32'hA5A5A5A5);
    funct = F_MFLO;
    #1 check("result mflo", result, 32'h5A5A5A5A);

    // unrelated funct is ignored
    @(negedge clk);
    start = 1'b1; funct = F_ADD; rs_data = 32'hFFFFFFFF; rt_data = 32'h0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("ignored hi", hi, 32'hA5A5A5A5);
    check("ignored lo", lo, 32'h5A5A5A5A);
    check("ignored busy", 32'(busy), 32'd0);
    check("ignored done", 32'(done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
